// File: rtl/tx_gearbox_66to32.sv
// Transmit 66b->32b gearbox: packs {sync, payload} blocks MSB-first into
// 32-bit words, inserts idle blocks when upstream is empty, and can insert
// single fill bits (slips) to shift the stream by a known bit offset.
// Ports:
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   en_i                  advance enable (low holds all state)
//   data_i, sync_i        block payload and sync header
//   data_valid_i          data_i/sync_i carry a real block
//   block_rd_o            block consumed at this edge (combinational)
//   slip_i                insert one SLIP_FILL bit this cycle
//   tx_word_o, tx_dv_o    output word (bit 31 first) and its update strobe
//   offset_o              cumulative slip count modulo 66
module tx_gearbox_66to32 #(
    parameter logic [1:0]  IDLE_SYNC    = 2'b10,
    parameter logic [63:0] IDLE_PAYLOAD = 64'h7800_0000_0000_0000,
    parameter logic        SLIP_FILL    = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        en_i,
    input  logic [63:0] data_i,
    input  logic [1:0]  sync_i,
    input  logic        data_valid_i,
    output logic        block_rd_o,
    input  logic        slip_i,
    output logic [31:0] tx_word_o,
    output logic        tx_dv_o,
    output logic [6:0]  offset_o
);

    localparam int unsigned BLK_W  = 66;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned BUF_W  = 98;
    localparam int unsigned CNT_W  = 7;

    logic [CNT_W-1:0]  r_q;
    logic [BUF_W-1:0]  buf_q;

    logic [CNT_W-1:0]  n_c;
    logic              rd_c;
    logic [BLK_W-1:0]  blk_c;
    logic [BUF_W-1:0]  keep_c;
    logic [BUF_W-1:0]  stream_c;
    logic [WORD_W-1:0] word_c;
    logic [BUF_W-1:0]  buf_nxt_c;
    logic [CNT_W-1:0]  r_nxt_c;

    // Stream assembly: residual bits, then the new block appended right after them.
    always_comb begin
        n_c       = slip_i ? CNT_W'(31) : CNT_W'(32);
        rd_c      = rst_ni && en_i && (r_q < n_c);
        blk_c     = data_valid_i ? {sync_i, data_i} : {IDLE_SYNC, IDLE_PAYLOAD};
        // Bits beyond R are cleared so the OR-merge below never sees stale data.
        keep_c    = buf_q & ~({BUF_W{1'b1}} >> r_q);
        stream_c  = keep_c;
        if (rd_c) begin
            stream_c = keep_c | ({blk_c, (BUF_W - BLK_W)'(0)} >> r_q);
        end
        word_c    = stream_c[BUF_W-1 -: WORD_W];
        buf_nxt_c = stream_c << 32;
        if (slip_i) begin
            word_c    = {SLIP_FILL, stream_c[BUF_W-1 -: WORD_W-1]};
            buf_nxt_c = stream_c << 31;
        end
        // R + 66 stays below 98 because a block loads only when R < N <= 32.
        r_nxt_c   = CNT_W'(8'(r_q) + (rd_c ? 8'd66 : 8'd0) - 8'(n_c));
    end

    assign block_rd_o = rd_c;

    // State and registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_q       <= '0;
            buf_q     <= '0;
            tx_word_o <= '0;
            tx_dv_o   <= 1'b0;
            offset_o  <= '0;
        end else if (en_i) begin
            r_q       <= r_nxt_c;
            buf_q     <= buf_nxt_c;
            tx_word_o <= word_c;
            tx_dv_o   <= 1'b1;
            if (slip_i) begin
                offset_o <= (offset_o == CNT_W'(65)) ? '0 : offset_o + CNT_W'(1);
            end
        end else begin
            tx_dv_o   <= 1'b0;
        end
    end

endmodule
